fetch_decode_unit: RTL and testbench

- Initiator side of the 256x16 instruction memory interface.
- Holds the program counter and drives the memory address.
- Reads the combinational 16-bit instruction word and decodes it into fields.
- Issues decoded instructions to the execute stage over a valid/ready handshake, resolves BRZ branches locally, and halts on an illegal opcode.

---
 rtl/isa_pkg.sv | 42 ++++
 rtl/instr_decoder.sv | 31 +++
 rtl/fetch_decode_unit.sv | 112 +++++++++++
 tb/tb_fetch_decode_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared instruction-set definitions for the 16-bit ISA: opcodes, field positions and the
// decoded-instruction record passed from the decoder to the fetch/decode control.
package isa_pkg;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_XNOR = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_BRZ  = 3'b011;
  localparam logic [2:0] OP_LDI  = 3'b100;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  // Fields as seen by the execute stage.
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;
  } dec_fields_t;

  typedef struct packed {
    dec_fields_t fields;
    logic        is_brz;
    logic        is_illegal;
    logic [7:0]  target;
  } dec_instr_t;

  function automatic logic op_is_illegal(logic [2:0] op);
    return op inside {3'b101, 3'b110, 3'b111};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction for one 16-bit instruction word, including branch and
// illegal-opcode detection.
module instr_decoder
  import isa_pkg::*;
(
  input  logic [15:0] instr,
  output dec_instr_t  dec
);

  logic [2:0] op;
  logic       unused_bit;

  assign op         = instr[OP_MSB:OP_LSB];
  assign unused_bit = instr[12];

  always_comb begin
    dec            = '0;
    dec.fields.op  = op;
    dec.fields.rd  = instr[RD_MSB:RD_LSB];
    dec.fields.rs1 = instr[RS1_MSB:RS1_LSB];
    dec.target     = instr[IMM_MSB:IMM_LSB];
    dec.is_illegal = op_is_illegal(op);
    case (op)
      OP_MUL, OP_XNOR: dec.fields.rs2 = instr[RS2_MSB:RS2_LSB];
      OP_LDI:          dec.fields.imm = instr[IMM_MSB:IMM_LSB];
      OP_BRZ:          dec.is_brz     = 1'b1;
      default:         ;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: owns the PC, issues decoded instructions over valid/ready,
// resolves BRZ once the execute stage drains, and stops on an illegal opcode.
module fetch_decode_unit
  import isa_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_instr,
  input  logic              exec_idle,
  input  logic              zero_flag,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [2:0]        dec_op,
  output logic [3:0]        dec_rd,
  output logic [3:0]        dec_rs1,
  output logic [3:0]        dec_rs2,
  output logic [7:0]        dec_imm,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [1:0] {StRun, StBrWait, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  dec_fields_t       fields_q, fields_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  dec_instr_t        dec;
  logic              slot_free;

  instr_decoder u_instr_decoder (
    .instr (imem_instr),
    .dec   (dec)
  );

  // A handshake this cycle frees the slot for the word fetched in the same cycle.
  assign slot_free = !valid_q || dec_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    fields_d  = fields_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StRun: begin
        if (slot_free) begin
          if (dec.is_illegal) begin
            valid_d   = 1'b0;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
            state_d   = StHalt;
          end else if (dec.is_brz) begin
            valid_d = 1'b0;
            state_d = StBrWait;
          end else begin
            fields_d = dec.fields;
            valid_d  = 1'b1;
            pc_d     = pc_q + ADDR_W'(1);
          end
        end
      end
      StBrWait: begin
        // The zero flag is only architectural once every issued instruction has retired.
        if (exec_idle) begin
          pc_d    = zero_flag ? ADDR_W'(dec.target) : pc_q + ADDR_W'(1);
          state_d = StRun;
        end
      end
      StHalt: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      fields_q  <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      fields_q  <= fields_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign dec_valid = valid_q;
  assign dec_op    = fields_q.op;
  assign dec_rd    = fields_q.rd;
  assign dec_rs1   = fields_q.rs1;
  assign dec_rs2   = fields_q.rs2;
  assign dec_imm   = fields_q.imm;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: instruction-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        exec_idle, zero_flag, dec_ready;
  logic        dec_valid, halted, illegal;
  logic [2:0]  dec_op;
  logic [3:0]  dec_rd, dec_rs1, dec_rs2;
  logic [7:0]  dec_imm, pc;

  logic [7:0]  w_addr, w_pc, w_imm;
  logic        w_valid, w_halted, w_illegal;
  logic [2:0]  w_op;
  logic [3:0]  w_rd, w_rs1, w_rs2;

  logic [15:0] mem [256];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_decode_unit #(.ADDR_W(8), .RESET_PC(8'd0)) dut (
    .clk (clk), .rst (rst), .imem_addr (imem_addr), .imem_instr (imem_instr),
    .exec_idle (exec_idle), .zero_flag (zero_flag), .dec_valid (dec_valid),
    .dec_ready (dec_ready), .dec_op (dec_op), .dec_rd (dec_rd), .dec_rs1 (dec_rs1),
    .dec_rs2 (dec_rs2), .dec_imm (dec_imm), .pc (pc), .halted (halted), .illegal (illegal)
  );

  // Second instance starting at the top of the address space; every word is MUL r1,r2,r3.
  fetch_decode_unit #(.ADDR_W(8), .RESET_PC(8'd255)) dut_wrap (
    .clk (clk), .rst (rst), .imem_addr (w_addr), .imem_instr (16'h0123),
    .exec_idle (1'b1), .zero_flag (1'b0), .dec_valid (w_valid),
    .dec_ready (1'b1), .dec_op (w_op), .dec_rd (w_rd), .dec_rs1 (w_rs1),
    .dec_rs2 (w_rs2), .dec_imm (w_imm), .pc (w_pc), .halted (w_halted), .illegal (w_illegal)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one instruction-level step per rising edge.
  bit         m_live = 0;
  int         m_pc;
  bit         m_valid, m_halt, m_ill, m_wait;
  int         m_op, m_rd, m_rs1, m_rs2, m_imm;

  always @(posedge clk) begin
    int w, op;
    if (rst) begin
      m_live = 1; m_pc = 0; m_valid = 0; m_halt = 0; m_ill = 0; m_wait = 0;
      m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
    end else if (m_live && !m_halt) begin
      w  = int'(mem[m_pc]);
      op = w / 8192;
      if (m_wait) begin
        if (exec_idle) begin
          m_pc   = zero_flag ? (w % 256) : (m_pc + 1) % 256;
          m_wait = 0;
        end
      end else if (!m_valid || dec_ready) begin
        if (op == 0 || op == 1 || op == 2 || op == 4) begin
          m_valid = 1;
          m_op    = op;
          m_rd    = (w / 256) % 16;
          m_rs1   = (w / 16) % 16;
          m_rs2   = (op <= 1) ? w % 16 : 0;
          m_imm   = (op == 4) ? w % 256 : 0;
          m_pc    = (m_pc + 1) % 256;
        end else if (op == 3) begin
          m_valid = 0;
          m_wait  = 1;
        end else begin
          m_valid = 0;
          m_halt  = 1;
          m_ill   = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model pc", int'(pc), m_pc);
      chk("model imem_addr", int'(imem_addr), m_pc);
      chk("model dec_valid", int'(dec_valid), int'(m_valid));
      chk("model halted", int'(halted), int'(m_halt));
      chk("model illegal", int'(illegal), int'(m_ill));
      if (m_valid) begin
        chk("model dec_op", int'(dec_op), m_op);
        chk("model dec_rd", int'(dec_rd), m_rd);
        chk("model dec_rs1", int'(dec_rs1), m_rs1);
        chk("model dec_rs2", int'(dec_rs2), m_rs2);
        chk("model dec_imm", int'(dec_imm), m_imm);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic fill_illegal();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  task automatic chk_dec(input string name, input int op, input int rd, input int rs1,
                         input int rs2, input int imm);
    chk({name, " valid"}, int'(dec_valid), 1);
    chk({name, " op"}, int'(dec_op), op);
    chk({name, " rd"}, int'(dec_rd), rd);
    chk({name, " rs1"}, int'(dec_rs1), rs1);
    chk({name, " rs2"}, int'(dec_rs2), rs2);
    chk({name, " imm"}, int'(dec_imm), imm);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, " valid"}, int'(dec_valid), 0);
    chk({name, " fields"}, int'({dec_op, dec_rd, dec_rs1, dec_rs2, dec_imm}), 0);
    chk({name, " halted"}, int'(halted), 0);
    chk({name, " illegal"}, int'(illegal), 0);
  endtask

  task automatic run_brz(input logic [15:0] word, input logic z, input int exp_pc);
    fill_illegal();
    mem[0] = 16'h0123; mem[1] = 16'h2345; mem[2] = 16'h4166; mem[3] = word;
    mem[4] = 16'h0123; mem[16] = 16'h0123;
    dec_ready = 1'b1; exec_idle = 1'b0; zero_flag = ~z;
    do_reset();
    cyc(3);
    chk("brz pre pc", int'(pc), 3);
    chk("brz pre valid", int'(dec_valid), 1);
    cyc(1);
    chk("brz bubble valid", int'(dec_valid), 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      chk("brz wait pc", int'(pc), 3);
      chk("brz wait valid", int'(dec_valid), 0);
    end
    exec_idle = 1'b1; zero_flag = z;
    cyc(1);
    chk("brz resolved pc", int'(pc), exp_pc);
    chk("brz resolved valid", int'(dec_valid), 0);
    cyc(1);
    chk("brz target issue", int'(dec_valid), 1);
    chk("brz target pc", int'(pc), exp_pc + 1);
  endtask

  initial begin
    rst = 1'b1; dec_ready = 1'b1; exec_idle = 1'b1; zero_flag = 1'b0;
    fill_illegal();
    mem[0] = 16'h0123; mem[1] = 16'h2345; mem[2] = 16'h4166; mem[3] = 16'h8308;

    // Straight-line issue at full throughput.
    cyc(2);
    rst = 1'b0;
    chk("reset pc", int'(pc), 0);
    chk_zero_outputs("reset");
    chk("wrap reset pc", int'(w_pc), 255);
    chk("wrap reset valid", int'(w_valid), 0);
    cyc(1);
    chk_dec("issue0", 0, 1, 2, 3, 0);
    chk("issue0 pc", int'(pc), 1);
    chk("wrap pc", int'(w_pc), 0);
    chk("wrap valid", int'(w_valid), 1);
    chk("wrap rd", int'(w_rd), 1);
    chk("wrap halted", int'(w_halted), 0);
    cyc(1);
    chk_dec("issue1", 1, 3, 4, 5, 0);
    cyc(1);
    chk_dec("issue2", 2, 1, 6, 0, 0);
    cyc(1);
    chk_dec("issue3", 4, 3, 0, 0, 8);
    chk("issue3 pc", int'(pc), 4);

    // Backpressure after the first issue.
    do_reset();
    cyc(1);
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk_dec("stall", 0, 1, 2, 3, 0);
      chk("stall pc", int'(pc), 1);
    end
    dec_ready = 1'b1;
    cyc(1);
    chk_dec("resume", 1, 3, 4, 5, 0);
    chk("resume pc", int'(pc), 2);

    // Branches: taken/not-taken with a self-next target and a distinct target.
    run_brz(16'h6004, 1'b1, 4);
    run_brz(16'h6004, 1'b0, 4);
    run_brz(16'h6010, 1'b1, 16);
    run_brz(16'h6010, 1'b0, 4);

    // Illegal opcode halts and stays halted.
    fill_illegal();
    mem[0] = 16'h0123; mem[1] = 16'h2345; mem[2] = 16'hA000;
    dec_ready = 1'b1; exec_idle = 1'b1;
    do_reset();
    cyc(3);
    for (int i = 0; i < 10; i++) begin
      chk("halt halted", int'(halted), 1);
      chk("halt illegal", int'(illegal), 1);
      chk("halt pc", int'(pc), 2);
      chk("halt valid", int'(dec_valid), 0);
      dec_ready = i[0];
      exec_idle = i[1];
      cyc(1);
    end

    // Reset while an instruction is stalled in the output slot.
    mem[2] = 16'h4166;
    dec_ready = 1'b1;
    do_reset();
    cyc(1);
    dec_ready = 1'b0;
    cyc(1);
    chk("pre-reset valid", int'(dec_valid), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid reset pc", int'(pc), 0);
    chk_zero_outputs("mid reset");
    dec_ready = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
